sync_fifo_flags: RTL

Parametrised single-clock FIFO, successor to the team's basic pointer FIFO. Adds:
- fill-level count
- programmable almost-full/almost-empty thresholds
- registered read-valid strobe
- sticky overflow/underflow error flags

Sits between same-clock producer/consumer stages as the standard buffering primitive. First-word-fall-through is available as a compile option.

---
 rtl/sync_fifo_flags.sv | 111 +++++++++++
 1 files changed

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: parametrised single-clock FIFO.
// It provides the fill-level count, programmable almost-full and almost-empty
// thresholds, a registered read-valid strobe, and sticky overflow/underflow
// error flags.
// Compile option: define SYNC_FIFO_FWFT_EN to select first-word-fall-through
// reads. When it is undefined, reads use the registered path with one cycle
// of latency.
module sync_fifo_flags #(
  parameter int DATA_WIDTH    = 8,
  parameter int DATA_DEPTH    = 16,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_valid,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [$clog2(DATA_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = $clog2(DATA_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] AFULL_LVL  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_LVL = CW'(AEMPTY_THRESH);

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [CW-1:0]         wr_ptr, rd_ptr;
  logic [AW-1:0]         wr_addr, rd_addr;
  logic                  wr_accept, rd_accept;
  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

  assign wr_addr = wr_ptr[AW-1:0];
  assign rd_addr = rd_ptr[AW-1:0];

  // The flags and the count come straight from the registered pointers.
  // They therefore describe the state before the current edge.
  assign count        = wr_ptr - rd_ptr;
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_addr == rd_addr);
  assign almost_full  = (count >= AFULL_LVL);
  assign almost_empty = (count <= AEMPTY_LVL);

  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;

  // Pointer update: advance on accepted operations only.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + CW'(1);
      if (rd_accept) rd_ptr <= rd_ptr + CW'(1);
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset so it can map onto RAM.
    // Stale contents are never visible because the pointers are reset.
    if (wr_accept) mem[wr_addr] <= wr_data;
  end

  // Sticky error flags: a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow  && !clr_err) || (wr_en && full);
      underflow <= (underflow && !clr_err) || (rd_en && empty);
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // The head word is presented combinationally, and rd_en acknowledges the pop.
  assign rd_data  = mem[rd_addr];
  assign rd_valid = !empty;
`else
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;

  // Registered read port: the data lands one cycle after the accept and
  // holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_accept;
      if (rd_accept) rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule
